// File: rtl/icache_miss_arbiter.sv
// I-cache miss arbiter: even/odd demand misses and next-line prefetch share one L2 read port.
// Optional prefetch deduplication is enabled by defining ICACHE_PF_DEDUP_EN.
module icache_miss_arbiter #(
  parameter int XLEN      = 32,
  parameter int LINE_BITS = 512
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dm_even_valid,
  input  logic [XLEN-1:0]      dm_even_addr,
  output logic                 dm_even_ready,
  input  logic                 dm_odd_valid,
  input  logic [XLEN-1:0]      dm_odd_addr,
  output logic                 dm_odd_ready,
  input  logic                 pf_valid,
  input  logic [XLEN-1:0]      pf_addr,
  output logic                 pf_ready,
  input  logic                 flush,
  output logic                 l2_req_valid,
  output logic [2:0]           l2_req_op,
  output logic [XLEN-1:0]      l2_req_addr,
  input  logic                 l2_req_ready,
  input  logic                 l2_rsp_valid,
  input  logic [LINE_BITS-1:0] l2_rsp_data,
  input  logic [2:0]           l2_rsp_state,
  output logic                 fill_valid,
  output logic [XLEN-1:0]      fill_addr,
  output logic [LINE_BITS-1:0] fill_data,
  output logic [2:0]           fill_state,
  output logic [1:0]           fill_src,
  output logic                 busy
);

  localparam logic [XLEN-1:0] LMASK = ~XLEN'(63);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_FILL
  } state_e;

  state_e               state_q, state_d;
  logic [XLEN-1:0]      addr_q, addr_d;
  logic [1:0]           src_q, src_d;
  logic [LINE_BITS-1:0] data_q, data_d;
  logic [2:0]           rstate_q, rstate_d;
  logic                 squash_q, squash_d;
  logic                 gnt_even, gnt_odd, gnt_pf;
  logic                 pf_drop, fire;

  always_comb begin
    gnt_even = 1'b0;
    gnt_odd  = 1'b0;
    gnt_pf   = 1'b0;
    if (state_q == S_IDLE && !flush) begin
      priority case (1'b1)
        dm_even_valid: gnt_even = 1'b1;
        dm_odd_valid:  gnt_odd  = 1'b1;
        pf_valid:      gnt_pf   = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef ICACHE_PF_DEDUP_EN
  logic [XLEN-1:0] lf_addr_q, lf_addr_d;
  logic            lf_vld_q, lf_vld_d;
  logic [XLEN-1:0] pf_line;
  logic            dup_lf, dup_even, dup_odd;

  assign pf_line  = pf_addr & LMASK;
  assign dup_lf   = lf_vld_q && (pf_line == lf_addr_q);
  assign dup_even = dm_even_valid
                 && ((dm_even_addr & LMASK) == pf_line);
  assign dup_odd  = dm_odd_valid
                 && ((dm_odd_addr & LMASK) == pf_line);
  assign pf_drop  = gnt_pf && (dup_lf || dup_even || dup_odd);

  // Only fills that reach the cache count as "recently fetched".
  always_comb begin
    lf_addr_d = lf_addr_q;
    lf_vld_d  = lf_vld_q;
    if (fill_valid) begin
      lf_addr_d = addr_q;
      lf_vld_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lf_addr_q <= '0;
      lf_vld_q  <= 1'b0;
    end else begin
      lf_addr_q <= lf_addr_d;
      lf_vld_q  <= lf_vld_d;
    end
  end
`else
  assign pf_drop = 1'b0;
`endif

  assign fire = gnt_even || gnt_odd || (gnt_pf && !pf_drop);

  always_comb begin
    addr_d   = addr_q;
    src_d    = src_q;
    data_d   = data_q;
    rstate_d = rstate_q;
    squash_d = squash_q;
    if (fire) begin
      if (gnt_even) begin
        addr_d = dm_even_addr & LMASK;
        src_d  = 2'd0;
      end else if (gnt_odd) begin
        addr_d = dm_odd_addr & LMASK;
        src_d  = 2'd1;
      end else begin
        addr_d = pf_addr & LMASK;
        src_d  = 2'd2;
      end
    end
    if (state_q == S_WAIT && l2_rsp_valid) begin
      data_d   = l2_rsp_data;
      rstate_d = l2_rsp_state;
    end
    if (state_q == S_IDLE) begin
      squash_d = 1'b0;
    end else if (flush) begin
      squash_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q   <= '0;
      src_q    <= '0;
      data_q   <= '0;
      rstate_q <= '0;
      squash_q <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      src_q    <= src_d;
      data_q   <= data_d;
      rstate_q <= rstate_d;
      squash_q <= squash_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (fire) state_d = S_REQ;
      S_REQ:  if (l2_req_ready) state_d = S_WAIT;
      S_WAIT: if (l2_rsp_valid) state_d = S_FILL;
      S_FILL: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Grants are gated by rst so nothing escapes while reset is held.
  always_comb begin
    dm_even_ready = rst && gnt_even;
    dm_odd_ready  = rst && gnt_odd;
    pf_ready      = rst && gnt_pf;
    l2_req_valid  = (state_q == S_REQ);
    l2_req_op     = l2_req_valid ? 3'd1 : 3'd0;
    l2_req_addr   = l2_req_valid ? addr_q : '0;
    fill_valid    = (state_q == S_FILL)
                 && !squash_q && !flush;
    fill_addr     = fill_valid ? addr_q : '0;
    fill_data     = fill_valid ? data_q : '0;
    fill_state    = fill_valid ? rstate_q : '0;
    fill_src      = fill_valid ? src_q : '0;
    busy          = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_icache_miss_arbiter.sv
// Self-checking bench for icache_miss_arbiter: directed scenarios plus
// randomized transactions against a transaction-level reference model.
module tb_icache_miss_arbiter;

  localparam int LB = 512;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          dm_even_valid = 0, dm_odd_valid = 0, pf_valid = 0;
  logic [31:0]   dm_even_addr = 0, dm_odd_addr = 0, pf_addr = 0;
  logic          dm_even_ready, dm_odd_ready, pf_ready;
  logic          flush = 0;
  logic          l2_req_valid;
  logic [2:0]    l2_req_op;
  logic [31:0]   l2_req_addr;
  logic          l2_req_ready = 0;
  logic          l2_rsp_valid = 0;
  logic [LB-1:0] l2_rsp_data = '0;
  logic [2:0]    l2_rsp_state = '0;
  logic          fill_valid;
  logic [31:0]   fill_addr;
  logic [LB-1:0] fill_data;
  logic [2:0]    fill_state;
  logic [1:0]    fill_src;
  logic          busy;

  int vec = 0;
  int errs = 0;

  icache_miss_arbiter #(.XLEN(32), .LINE_BITS(LB)) dut (
    .clk(clk), .rst(rst),
    .dm_even_valid(dm_even_valid), .dm_even_addr(dm_even_addr),
    .dm_even_ready(dm_even_ready),
    .dm_odd_valid(dm_odd_valid), .dm_odd_addr(dm_odd_addr),
    .dm_odd_ready(dm_odd_ready),
    .pf_valid(pf_valid), .pf_addr(pf_addr), .pf_ready(pf_ready),
    .flush(flush),
    .l2_req_valid(l2_req_valid), .l2_req_op(l2_req_op),
    .l2_req_addr(l2_req_addr), .l2_req_ready(l2_req_ready),
    .l2_rsp_valid(l2_rsp_valid), .l2_rsp_data(l2_rsp_data),
    .l2_rsp_state(l2_rsp_state),
    .fill_valid(fill_valid), .fill_addr(fill_addr),
    .fill_data(fill_data), .fill_state(fill_state),
    .fill_src(fill_src), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, vectors=%0d", vec);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LB-1:0] rnd_line();
    logic [LB-1:0] r;
    for (int i = 0; i < LB / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Drives the L2 side of one granted transaction and records what it saw.
  // Entered one cycle after the grant edge. fmode: 0 none, 1 flush in WAIT,
  // 2 flush coincident with the response.
  task automatic serve(
    input  int            rdy_dly,
    input  int            rsp_dly,
    input  logic [LB-1:0] d,
    input  logic [2:0]    st,
    input  int            fmode,
    output int            vcyc,
    output logic          stable,
    output logic [31:0]   raddr,
    output logic          fv,
    output logic [31:0]   fa,
    output logic [LB-1:0] fd,
    output logic [2:0]    fs,
    output logic [1:0]    fsrc,
    output logic          busy_after
  );
    vcyc = 0;
    stable = 1'b1;
    #1;
    raddr = l2_req_addr;
    for (int i = 0; i <= rdy_dly; i++) begin
      l2_req_ready = (i == rdy_dly);
      #1;
      if (l2_req_valid) vcyc++;
      if (l2_req_addr !== raddr || l2_req_op !== 3'd1) stable = 1'b0;
      tick();
    end
    l2_req_ready = 1'b0;
    for (int j = 0; j < rsp_dly; j++) begin
      flush = (fmode == 1 && j == 0);
      #1;
      if (l2_req_valid) vcyc++;
      tick();
    end
    flush = (fmode == 2);
    l2_rsp_valid = 1'b1;
    l2_rsp_data = d;
    l2_rsp_state = st;
    tick();
    flush = 1'b0;
    l2_rsp_valid = 1'b0;
    l2_rsp_data = '0;
    #1;
    fv = fill_valid;
    fa = fill_addr;
    fd = fill_data;
    fs = fill_state;
    fsrc = fill_src;
    tick();
    #1;
    busy_after = busy;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    dm_even_valid = 1'b1;
    dm_even_addr = 32'h0000_1234;
    #1;
    vec++;
    if ({dm_even_ready, dm_odd_ready, pf_ready} !== 3'b000) begin
      errs++;
      $display("FAIL reset_ready: got %b want 000",
               {dm_even_ready, dm_odd_ready, pf_ready});
    end
    vec++;
    if ({busy, l2_req_valid, fill_valid, l2_req_op} !== 6'd0) begin
      errs++;
      $display("FAIL reset_outs: got busy=%b req=%b fill=%b op=%0d want 0",
               busy, l2_req_valid, fill_valid, l2_req_op);
    end
    tick();
    tick();
    vec++;
    if (busy !== 1'b0 || l2_req_addr !== 32'd0) begin
      errs++;
      $display("FAIL reset_held: got busy=%b addr=%h want 0 0",
               busy, l2_req_addr);
    end
    dm_even_valid = 1'b0;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_priority();
    int vc;
    logic st_ok, fv, ba;
    logic [31:0] ra, fa;
    logic [LB-1:0] fd, d;
    logic [2:0] fs, s;
    logic [1:0] fsrc;
    dm_even_valid = 1'b1; dm_even_addr = 32'h1000;
    dm_odd_valid = 1'b1;  dm_odd_addr = 32'h1040;
    pf_valid = 1'b1;      pf_addr = 32'h1080;
    for (int k = 0; k < 3; k++) begin
      #1;
      vec++;
      if ({dm_even_ready, dm_odd_ready, pf_ready} !== (3'b100 >> k)) begin
        errs++;
        $display("FAIL prio_grant%0d: got %b want %b", k,
                 {dm_even_ready, dm_odd_ready, pf_ready}, 3'b100 >> k);
      end
      tick();
      if (k == 0) dm_even_valid = 1'b0;
      if (k == 1) dm_odd_valid = 1'b0;
      if (k == 2) pf_valid = 1'b0;
      d = rnd_line();
      s = 3'($urandom_range(7, 0));
      serve(0, 1, d, s, 0, vc, st_ok, ra, fv, fa, fd, fs, fsrc, ba);
      vec++;
      if (ra !== 32'h1000 + 32'h40 * k || vc !== 1) begin
        errs++;
        $display("FAIL prio_req%0d: got addr=%h cycles=%0d want %h 1",
                 k, ra, vc, 32'h1000 + 32'h40 * k);
      end
      vec++;
      if (fv !== 1'b1 || fsrc !== 2'(k) || fa !== 32'h1000 + 32'h40 * k) begin
        errs++;
        $display("FAIL prio_fill%0d: got v=%b src=%0d addr=%h want 1 %0d %h",
                 k, fv, fsrc, fa, k, 32'h1000 + 32'h40 * k);
      end
      vec++;
      if (fd !== d || fs !== s) begin
        errs++;
        $display("FAIL prio_data%0d: got state=%0d data=%h want %0d %h",
                 k, fs, fd, s, d);
      end
    end
  endtask

  task automatic test_hold();
    int vc;
    logic st_ok, fv, ba;
    logic [31:0] ra, fa;
    logic [LB-1:0] fd;
    logic [2:0] fs;
    logic [1:0] fsrc;
    dm_even_valid = 1'b1;
    dm_even_addr = 32'h2013;
    tick();
    dm_even_valid = 1'b0;
    serve(5, 2, {LB/8{8'h5c}}, 3'd2, 0, vc, st_ok, ra, fv, fa, fd, fs, fsrc, ba);
    vec++;
    if (ra !== 32'h2000 || !st_ok || vc !== 6) begin
      errs++;
      $display("FAIL hold_req: got addr=%h stable=%b cycles=%0d want 2000 1 6",
               ra, st_ok, vc);
    end
    vec++;
    if (fv !== 1'b1 || fa !== 32'h2000 || fsrc !== 2'd0 || ba !== 1'b0) begin
      errs++;
      $display("FAIL hold_fill: got v=%b addr=%h src=%0d busy=%b want 1 2000 0 0",
               fv, fa, fsrc, ba);
    end
  endtask

  task automatic test_flush();
    int vc;
    logic st_ok, fv, ba;
    logic [31:0] ra, fa;
    logic [LB-1:0] fd;
    logic [2:0] fs;
    logic [1:0] fsrc;
    for (int m = 1; m <= 2; m++) begin
      dm_odd_valid = 1'b1;
      dm_odd_addr = 32'h0000_7788;
      tick();
      dm_odd_valid = 1'b0;
      serve(1, 2, {LB/8{8'hAA}}, 3'd1, m, vc, st_ok, ra, fv, fa, fd, fs, fsrc, ba);
      vec++;
      if (fv !== 1'b0 || fd !== '0 || ba !== 1'b0 || vc !== 2) begin
        errs++;
        $display("FAIL flush_m%0d: got fill=%b busy=%b cycles=%0d want 0 0 2",
                 m, fv, ba, vc);
      end
    end
    dm_even_valid = 1'b1;
    dm_even_addr = 32'h4000;
    #1;
    vec++;
    if (dm_even_ready !== 1'b1) begin
      errs++;
      $display("FAIL flush_regrant: got ready=%b want 1", dm_even_ready);
    end
    tick();
    dm_even_valid = 1'b0;
    serve(0, 1, {LB/8{8'h11}}, 3'd3, 0, vc, st_ok, ra, fv, fa, fd, fs, fsrc, ba);
    vec++;
    if (fv !== 1'b1 || fa !== 32'h4000 || fs !== 3'd3) begin
      errs++;
      $display("FAIL flush_after: got v=%b addr=%h state=%0d want 1 4000 3",
               fv, fa, fs);
    end
  endtask

  task automatic test_reset_mid();
    dm_even_valid = 1'b1;
    dm_even_addr = 32'h5000;
    tick();
    dm_even_valid = 1'b0;
    l2_req_ready = 1'b1;
    tick();
    l2_req_ready = 1'b0;
    rst = 1'b0;
    #1;
    vec++;
    if ({busy, l2_req_valid, fill_valid} !== 3'b000) begin
      errs++;
      $display("FAIL rstmid_assert: got busy=%b req=%b fill=%b want 000",
               busy, l2_req_valid, fill_valid);
    end
    tick();
    rst = 1'b1;
    tick();
    l2_rsp_valid = 1'b1;
    l2_rsp_data = {LB/8{8'h77}};
    tick();
    l2_rsp_valid = 1'b0;
    #1;
    vec++;
    if ({busy, l2_req_valid, fill_valid} !== 3'b000) begin
      errs++;
      $display("FAIL rstmid_rsp: got busy=%b req=%b fill=%b want 000",
               busy, l2_req_valid, fill_valid);
    end
  endtask

  task automatic test_dedup();
    int vc;
    logic st_ok, fv, ba;
    logic [31:0] ra, fa;
    logic [LB-1:0] fd;
    logic [2:0] fs;
    logic [1:0] fsrc;
    dm_even_valid = 1'b1;
    dm_even_addr = 32'h3000;
    tick();
    dm_even_valid = 1'b0;
    serve(0, 1, {LB/8{8'h33}}, 3'd0, 0, vc, st_ok, ra, fv, fa, fd, fs, fsrc, ba);
    pf_valid = 1'b1;
    pf_addr = 32'h3004;
    #1;
    vec++;
    if (pf_ready !== 1'b1) begin
      errs++;
      $display("FAIL dedup_ready: got %b want 1", pf_ready);
    end
    tick();
    pf_valid = 1'b0;
    #1;
`ifdef ICACHE_PF_DEDUP_EN
    vec++;
    if ({busy, l2_req_valid} !== 2'b00) begin
      errs++;
      $display("FAIL dedup_drop: got busy=%b req=%b want 0 0",
               busy, l2_req_valid);
    end
`else
    vec++;
    if (l2_req_valid !== 1'b1 || l2_req_addr !== 32'h3000) begin
      errs++;
      $display("FAIL dedup_off: got req=%b addr=%h want 1 3000",
               l2_req_valid, l2_req_addr);
    end
    serve(0, 1, {LB/8{8'h44}}, 3'd0, 0, vc, st_ok, ra, fv, fa, fd, fs, fsrc, ba);
    vec++;
    if (fv !== 1'b1 || fsrc !== 2'd2) begin
      errs++;
      $display("FAIL dedup_off_fill: got v=%b src=%0d want 1 2", fv, fsrc);
    end
`endif
  endtask

  // Transaction-level model: winner by priority list, line = addr & ~63,
  // fill only when no flush touched the transaction.
  task automatic test_random();
    logic [31:0] lf;
    logic lf_v;
    logic vld [3];
    logic [31:0] adr [3];
    int win, fmode, rdy, rsp, vc;
    logic drop, st_ok, fv, ba;
    logic [31:0] ra, fa, line;
    logic [LB-1:0] fd, d;
    logic [2:0] fs, s;
    logic [1:0] fsrc;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    lf_v = 1'b0;
    lf = '0;
    for (int t = 0; t < 40; t++) begin
      vld[0] = 1'($urandom % 2);
      vld[1] = 1'($urandom % 2);
      vld[2] = 1'($urandom % 2);
      if (!vld[0] && !vld[1]) vld[2] = 1'b1;
      adr[0] = $urandom;
      adr[1] = $urandom;
      adr[2] = (lf_v && $urandom % 3 == 0) ? (lf | $urandom_range(63, 0))
                                           : $urandom;
      win = vld[0] ? 0 : (vld[1] ? 1 : 2);
      line = adr[win] & ~32'h3f;
      drop = 1'b0;
`ifdef ICACHE_PF_DEDUP_EN
      drop = (win == 2) && lf_v && (line == lf);
`endif
      dm_even_valid = vld[0]; dm_even_addr = adr[0];
      dm_odd_valid = vld[1];  dm_odd_addr = adr[1];
      pf_valid = vld[2];      pf_addr = adr[2];
      if ($urandom % 8 == 0) begin
        flush = 1'b1;
        #1;
        vec++;
        if ({dm_even_ready, dm_odd_ready, pf_ready} !== 3'b000) begin
          errs++;
          $display("FAIL rnd_idleflush%0d: got %b want 000", t,
                   {dm_even_ready, dm_odd_ready, pf_ready});
        end
        tick();
        flush = 1'b0;
      end
      #1;
      vec++;
      if ({dm_even_ready, dm_odd_ready, pf_ready} !== (3'b100 >> win)) begin
        errs++;
        $display("FAIL rnd_grant%0d: got %b want %b", t,
                 {dm_even_ready, dm_odd_ready, pf_ready}, 3'b100 >> win);
      end
      tick();
      dm_even_valid = 1'b0;
      dm_odd_valid = 1'b0;
      pf_valid = 1'b0;
      if (drop) begin
        #1;
        vec++;
        if ({busy, l2_req_valid} !== 2'b00) begin
          errs++;
          $display("FAIL rnd_drop%0d: got busy=%b req=%b want 0 0",
                   t, busy, l2_req_valid);
        end
        continue;
      end
      fmode = $urandom % 6;
      fmode = (fmode < 4) ? 0 : fmode - 3;
      rdy = $urandom_range(3, 0);
      rsp = $urandom_range(3, 1);
      d = rnd_line();
      s = 3'($urandom_range(7, 0));
      serve(rdy, rsp, d, s, fmode, vc, st_ok, ra, fv, fa, fd, fs, fsrc, ba);
      vec++;
      if (ra !== line || !st_ok || vc !== rdy + 1 || ba !== 1'b0) begin
        errs++;
        $display("FAIL rnd_req%0d: got addr=%h stable=%b cyc=%0d busy=%b want %h 1 %0d 0",
                 t, ra, st_ok, vc, ba, line, rdy + 1);
      end
      vec++;
      if (fv !== (fmode == 0)) begin
        errs++;
        $display("FAIL rnd_fillv%0d: got %b want %b", t, fv, fmode == 0);
      end
      if (fmode == 0) begin
        vec++;
        if (fa !== line || fsrc !== 2'(win) || fd !== d || fs !== s) begin
          errs++;
          $display("FAIL rnd_fill%0d: got addr=%h src=%0d st=%0d want %h %0d %0d",
                   t, fa, fsrc, fs, line, win, s);
        end
        lf = line;
        lf_v = 1'b1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_hold();
    test_flush();
    test_reset_mid();
    test_dedup();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
